// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller for the debug/boundary-scan datapath.
// Runs the 16-state TAP FSM, owns the IR, bypass and optional IDCODE DRs, drives
// the boundary-scan strobes and a sticky halt request. Everything is in tck domain.
// Optional feature macro: JTAG_IDCODE_EN (adds 32-bit IDCODE DR, default IR = IDCODE).
module jtag_tap_ctrl #(
    parameter int unsigned IR_W = 4
`ifdef JTAG_IDCODE_EN
    ,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
`endif
) (
    input  logic tck,
    input  logic trst,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    input  logic bsr_tdo,
    output logic dr_tdi,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic sel_extest,
    output logic halt_req
);

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SHIFT_DR, ST_EXIT1_DR, ST_PAUSE_DR, ST_EXIT2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SHIFT_IR, ST_EXIT1_IR, ST_PAUSE_IR, ST_EXIT2_IR, ST_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_BSR,
        DR_IDCODE
    } dr_sel_e;

    localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(4'b0000);
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(4'b0010);
    localparam logic [IR_W-1:0] OP_HALT    = IR_W'(4'b0110);
    localparam logic [IR_W-1:0] OP_RESUME  = IR_W'(4'b0111);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'b0001);
    localparam logic [IR_W-1:0] IR_DEFAULT = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_DEFAULT = IR_W'(4'b1111);
`endif

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic            bypass_q, bypass_d;
    logic            halt_q, halt_d;
    logic            tdo_q, tdo_en_q;
    logic            tdo_src;
    logic            shifting;
    dr_sel_e         dr_sel;

    // TAP state register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state_q <= ST_TLR;
        else       state_q <= state_d;
    end

    // Standard 1149.1 next-state transitions
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
            default:     state_d = ST_TLR;
        endcase
    end

    // Instruction decode: unknown opcodes (and HALT/RESUME) fall back to bypass
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OP_EXTEST || ir_q == OP_SAMPLE) begin
            dr_sel = DR_BSR;
        end
`ifdef JTAG_IDCODE_EN
        else if (ir_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
`endif
    end

    // IR shift/update, bypass bit and sticky halt next-state
    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_d     = ir_q;
        halt_d   = halt_q;
        bypass_d = bypass_q;
        if (state_q == ST_CAP_IR)   ir_sr_d = IR_W'(1);
        if (state_q == ST_SHIFT_IR) ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
        if (state_q == ST_UPD_IR) begin
            ir_d = ir_sr_q;
            if (ir_sr_q == OP_HALT)        halt_d = 1'b1;
            else if (ir_sr_q == OP_RESUME) halt_d = 1'b0;
        end
        if (state_q == ST_TLR) ir_d = IR_DEFAULT;
        if (dr_sel == DR_BYPASS) begin
            if (state_q == ST_CAP_DR)   bypass_d = 1'b0;
            if (state_q == ST_SHIFT_DR) bypass_d = tdi;
        end
    end

    // IR, IR shift register, bypass and halt registers
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_q     <= IR_DEFAULT;
            ir_sr_q  <= '0;
            bypass_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            ir_sr_q  <= ir_sr_d;
            bypass_q <= bypass_d;
            halt_q   <= halt_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    // IDCODE DR: capture the device ID, then shift right with tdi entering bit 31
    always_comb begin
        idcode_d = idcode_q;
        if (dr_sel == DR_IDCODE) begin
            if (state_q == ST_CAP_DR)   idcode_d = IDCODE_VALUE;
            if (state_q == ST_SHIFT_DR) idcode_d = {tdi, idcode_q[31:1]};
        end
    end

    // IDCODE DR register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) idcode_q <= '0;
        else       idcode_q <= idcode_d;
    end
`endif

    // TDO source select from the current state and the decoded DR
    always_comb begin
        shifting = (state_q == ST_SHIFT_IR) || (state_q == ST_SHIFT_DR);
        tdo_src  = 1'b0;
        if (state_q == ST_SHIFT_IR) begin
            tdo_src = ir_sr_q[0];
        end else begin
            unique case (dr_sel)
                DR_BSR:    tdo_src = bsr_tdo;
`ifdef JTAG_IDCODE_EN
                DR_IDCODE: tdo_src = idcode_q[0];
`endif
                default:   tdo_src = bypass_q;
            endcase
        end
    end

    // TDO and pad enable update on the falling edge; TDO is forced low when idle
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= shifting;
            tdo_q    <= shifting ? tdo_src : 1'b0;
        end
    end

    // Boundary-scan strobes are pure state decodes gated by BSR selection
    always_comb begin
        capture_dr = (state_q == ST_CAP_DR)   && (dr_sel == DR_BSR);
        shift_dr   = (state_q == ST_SHIFT_DR) && (dr_sel == DR_BSR);
        update_dr  = (state_q == ST_UPD_DR)   && (dr_sel == DR_BSR);
        sel_extest = (ir_q == OP_EXTEST);
    end

    assign dr_tdi   = tdi;
    assign tdo      = tdo_q;
    assign tdo_en   = tdo_en_q;
    assign halt_req = halt_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: randomized bench for jtag_tap_ctrl with a behavioural TAP model.
// Honours JTAG_IDCODE_EN the same way as the design.
module tb_jtag_tap_ctrl;

    logic tck = 1'b0;
    logic trst = 1'b0;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic bsr_tdo = 1'b0;
    logic tdo, tdo_en, dr_tdi, capture_dr, shift_dr, update_dr, sel_extest, halt_req;

    jtag_tap_ctrl dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .bsr_tdo(bsr_tdo), .dr_tdi(dr_tdi), .capture_dr(capture_dr), .shift_dr(shift_dr),
        .update_dr(update_dr), .sel_extest(sel_extest), .halt_req(halt_req)
    );

    always #5 tck = ~tck;

`ifdef JTAG_IDCODE_EN
    localparam int DEF_IR = 1;
    localparam bit HAS_ID = 1'b1;
`else
    localparam int DEF_IR = 15;
    localparam bit HAS_ID = 1'b0;
`endif
    localparam logic [31:0] IDV = 32'h1000_0001;

    // TAP states in diagram order, with a transition table per tms value
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PSDR = 6,
                   EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                   PSIR = 13, EX2IR = 14, UPIR = 15;
    int nxt0[16] = '{RTI, RTI, CAPDR, SHDR, SHDR, PSDR, PSDR, SHDR, RTI,
                     CAPIR, SHIR, SHIR, PSIR, PSIR, SHIR, RTI};
    int nxt1[16] = '{TLR, SELDR, SELIR, EX1DR, EX1DR, UPDR, EX2DR, UPDR, SELDR,
                     TLR, EX1IR, EX1IR, UPIR, EX2IR, UPIR, SELDR};

    int          m_st, m_ir, m_irsr, m_byp, m_halt, m_tdo, m_en;
    logic [31:0] m_id;
    int          n_checks, n_fail;
    int          cnt_cap, cnt_shift, cnt_upd;
    logic        last_tdo;
    logic [255:0] out_bits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // 0 = bypass, 1 = boundary scan, 2 = idcode
    function automatic int kind(input int ir);
        if (ir == 0 || ir == 2) return 1;
        if (HAS_ID && ir == 1) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = TLR; m_ir = DEF_IR; m_irsr = 0; m_byp = 0;
        m_halt = 0; m_tdo = 0; m_en = 0; m_id = '0;
    endtask

    task automatic model_pos(input logic tms_v, input logic tdi_v);
        int k;
        k = kind(m_ir);
        if (m_st == CAPIR) m_irsr = 1;
        if (m_st == SHIR)  m_irsr = (m_irsr >> 1) | (int'(tdi_v) << 3);
        if (m_st == UPIR) begin
            m_ir = m_irsr;
            if (m_irsr == 6) m_halt = 1;
            if (m_irsr == 7) m_halt = 0;
        end
        if (m_st == TLR) m_ir = DEF_IR;
        if (m_st == CAPDR) begin
            if (k == 0) m_byp = 0;
            if (k == 2) m_id = IDV;
        end
        if (m_st == SHDR) begin
            if (k == 0) m_byp = int'(tdi_v);
            if (k == 2) m_id = {tdi_v, m_id[31:1]};
        end
        m_st = tms_v ? nxt1[m_st] : nxt0[m_st];
    endtask

    task automatic model_neg(input logic bsr_v);
        int k;
        k = kind(m_ir);
        m_en = (m_st == SHIR || m_st == SHDR) ? 1 : 0;
        if (m_en == 0)         m_tdo = 0;
        else if (m_st == SHIR) m_tdo = m_irsr & 1;
        else if (k == 1)       m_tdo = int'(bsr_v);
        else if (k == 2)       m_tdo = int'(m_id[0]);
        else                   m_tdo = m_byp;
    endtask

    // One tck cycle: drive inputs after a falling edge, compare after the next one
    task automatic step(input logic tms_v, input logic tdi_v);
        int k;
        tms = tms_v; tdi = tdi_v; bsr_tdo = 1'($urandom_range(0, 1));
        #1;
        check("dr_tdi", 32'(dr_tdi), 32'(tdi_v));
        @(posedge tck);
        model_pos(tms_v, tdi_v);
        @(negedge tck);
        model_neg(bsr_tdo);
        #1;
        k = kind(m_ir);
        check("tdo", 32'(tdo), 32'(m_tdo));
        check("tdo_en", 32'(tdo_en), 32'(m_en));
        check("halt_req", 32'(halt_req), 32'(m_halt));
        check("sel_extest", 32'(sel_extest), 32'(m_ir == 0));
        check("capture_dr", 32'(capture_dr), 32'(m_st == CAPDR && k == 1));
        check("shift_dr", 32'(shift_dr), 32'(m_st == SHDR && k == 1));
        check("update_dr", 32'(update_dr), 32'(m_st == UPDR && k == 1));
        cnt_cap += int'(capture_dr);
        cnt_shift += int'(shift_dr);
        cnt_upd += int'(update_dr);
        last_tdo = tdo;
    endtask

    // Async reset held across one rising edge, released just after a falling edge
    task automatic pulse_trst();
        trst = 1'b0;
        #1;
        model_reset();
        check("rst_tdo", 32'(tdo), 32'd0);
        check("rst_tdo_en", 32'(tdo_en), 32'd0);
        check("rst_halt", 32'(halt_req), 32'd0);
        check("rst_strobes", {29'd0, capture_dr, shift_dr, update_dr}, 32'd0);
        check("rst_extest", 32'(sel_extest), 32'd0);
        @(negedge tck);
        #1;
        trst = 1'b1;
    endtask

    task automatic goto_rti();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: load an opcode LSB first and return to Run-Test/Idle
    task automatic load_ir(input logic [3:0] v);
        logic [3:0] cap;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        cap[0] = last_tdo;
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
            if (i < 3) cap[i+1] = last_tdo;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        check("ir_capture", 32'(cap), 32'h1);
    endtask

    // From Run-Test/Idle: shift n DR bits, collecting the n bits seen on tdo
    task automatic shift_dr_seq(input int n, input logic [255:0] data);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        out_bits = '0;
        out_bits[0] = last_tdo;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, data[i]);
            if (i < n - 1) out_bits[i+1] = last_tdo;
        end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    initial begin
        logic [255:0] d;
        logic [3:0]   ops[6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hF};
        n_checks = 0; n_fail = 0;
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
        last_tdo = 1'b0;
        model_reset();
        #2;
        check("init_tdo", 32'(tdo), 32'd0);
        check("init_tdo_en", 32'(tdo_en), 32'd0);
        check("init_halt", 32'(halt_req), 32'd0);
        @(negedge tck);
        #1;
        trst = 1'b1;

        // Reset via tms and the default instruction's DR
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("tlr_tdo_en", 32'(tdo_en), 32'd0);
        step(1'b0, 1'b0);
        d = '0;
        d[31:0] = 32'($urandom);
        shift_dr_seq(32, d);
        check("default_dr", out_bits[31:0], HAS_ID ? IDV : {d[30:0], 1'b0});

        // HALT is sticky across Test-Logic-Reset
        load_ir(4'b0110);
        check("halt_set", 32'(halt_req), 32'd1);
        goto_rti();
        check("halt_sticky", 32'(halt_req), 32'd1);

        // SAMPLE_PRELOAD over a 161-bit chain
        load_ir(4'b0010);
        cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        shift_dr_seq(161, d);
        check("bsr_shift_cycles", 32'(cnt_shift), 32'd161);
        check("bsr_capture_pulses", 32'(cnt_cap), 32'd1);
        check("bsr_update_pulses", 32'(cnt_upd), 32'd1);

        // BYPASS: one-bit latency, first bit out is the captured 0
        load_ir(4'b1111);
        d = '0;
        d[7:0] = 8'hA5;
        shift_dr_seq(9, d);
        check("bypass_first", 32'(out_bits[0]), 32'd0);
        check("bypass_data", 32'(out_bits[8:1]), 32'hA5);

        // RESUME drops the halt request
        load_ir(4'b0111);
        check("halt_clear", 32'(halt_req), 32'd0);

        // HALT again, then trst in the middle of a DR shift
        load_ir(4'b0110);
        goto_rti();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'($urandom_range(0, 1)));
        check("mid_shift_en", 32'(tdo_en), 32'd1);
        pulse_trst();
        step(1'b0, 1'b0);

        // Random walk with occasional instruction loads and resets
        for (int it = 0; it < 2500; it++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                pulse_trst();
            end else if (r < 6) begin
                goto_rti();
                if (r < 4) load_ir(ops[$urandom_range(0, 5)]);
                else       load_ir(4'($urandom_range(0, 15)));
            end else begin
                step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
